// File: rtl/decode_forward_stage.sv
// Decode/forwarding datapath: F/D and D/E pipeline registers, operand forward muxes and bubble injection.
// Optional stall cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module decode_forward_stage #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDR_WIDTH    = 32,
  parameter int          REGISTER_SIZE = 5,
  parameter logic [31:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_instr,
  input  logic [ADDR_WIDTH-1:0]    fetch_pc,
  input  logic                     fetch_valid,
  input  logic                     flush,
  input  logic                     f_to_d_enable_ff,
  input  logic                     d_to_e_enable_ff,
  input  logic [1:0][1:0]          pipeline_forward_sel,
  input  logic [DATA_WIDTH-1:0]    rf_data1,
  input  logic [DATA_WIDTH-1:0]    rf_data2,
  input  logic [DATA_WIDTH-1:0]    ex_alu_data,
  input  logic [DATA_WIDTH-1:0]    ma_alu_data,
  input  logic [DATA_WIDTH-1:0]    ma_dm_data,
  output logic [REGISTER_SIZE-1:0] decode_source_reg1,
  output logic [REGISTER_SIZE-1:0] decode_source_reg2,
  output logic [REGISTER_SIZE-1:0] decode_destination_reg,
  output logic                     decode_valid,
  output logic [31:0]              execute_instr,
  output logic [ADDR_WIDTH-1:0]    execute_pc,
  output logic [DATA_WIDTH-1:0]    execute_operand_a,
  output logic [DATA_WIDTH-1:0]    execute_operand_b,
  output logic [REGISTER_SIZE-1:0] execute_destination_reg,
  output logic                     execute_valid,
  output logic                     protocol_error,
  output logic [31:0]              stall_count
);

  logic [31:0]           fd_instr;
  logic [ADDR_WIDTH-1:0] fd_pc;
  logic                  fd_valid;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  assign decode_source_reg1     = fd_instr[15 +: REGISTER_SIZE];
  assign decode_source_reg2     = fd_instr[20 +: REGISTER_SIZE];
  assign decode_destination_reg = fd_instr[7 +: REGISTER_SIZE];
  assign decode_valid           = fd_valid;

  // Flush kills the decode slot; PC is left as-is since it is dead once valid drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fd_instr <= NOP_INSTR;
      fd_pc    <= '0;
      fd_valid <= 1'b0;
    end else if (flush) begin
      fd_instr <= NOP_INSTR;
      fd_valid <= 1'b0;
    end else if (f_to_d_enable_ff) begin
      fd_instr <= fetch_instr;
      fd_pc    <= fetch_pc;
      fd_valid <= fetch_valid;
    end
  end

  // x0 always reads as zero, whatever the hazard unit selects.
  always_comb begin
    fwd_a = rf_data1;
    fwd_b = rf_data2;
    case (pipeline_forward_sel[0])
      2'd0:    fwd_a = rf_data1;
      2'd1:    fwd_a = ma_dm_data;
      2'd2:    fwd_a = ex_alu_data;
      default: fwd_a = ma_alu_data;
    endcase
    case (pipeline_forward_sel[1])
      2'd0:    fwd_b = rf_data2;
      2'd1:    fwd_b = ma_dm_data;
      2'd2:    fwd_b = ex_alu_data;
      default: fwd_b = ma_alu_data;
    endcase
    if (decode_source_reg1 == '0) fwd_a = '0;
    if (decode_source_reg2 == '0) fwd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush || !d_to_e_enable_ff) begin
      execute_instr           <= NOP_INSTR;
      execute_pc              <= '0;
      execute_operand_a       <= '0;
      execute_operand_b       <= '0;
      execute_destination_reg <= '0;
      execute_valid           <= 1'b0;
    end else begin
      execute_instr           <= fd_instr;
      execute_pc              <= fd_pc;
      execute_operand_a       <= fwd_a;
      execute_operand_b       <= fwd_b;
      execute_destination_reg <= fd_valid ? decode_destination_reg : '0;
      execute_valid           <= fd_valid;
    end
  end

  // Decode held while execute loads would duplicate the instruction downstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      protocol_error <= 1'b0;
    end else if (!flush && !f_to_d_enable_ff && d_to_e_enable_ff) begin
      protocol_error <= 1'b1;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!flush && !d_to_e_enable_ff && stall_q != 32'hFFFFFFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_decode_forward_stage.sv
// Self-checking bench for decode_forward_stage: directed test-plan steps followed by a randomized run
// against a cycle-level behavioural model of the pipeline registers.
module tb_decode_forward_stage;

   logic              clock;
   logic              rst;
   logic [31:0]       fetch_instr;
   logic [31:0]       fetch_pc;
   logic              fetch_valid;
   logic              flush;
   logic              f_to_d_enable_ff;
   logic              d_to_e_enable_ff;
   logic [1:0][1:0]   pipeline_forward_sel;
   logic [31:0]       rf_data1;
   logic [31:0]       rf_data2;
   logic [31:0]       ex_alu_data;
   logic [31:0]       ma_alu_data;
   logic [31:0]       ma_dm_data;
   logic [4:0]        decode_source_reg1;
   logic [4:0]        decode_source_reg2;
   logic [4:0]        decode_destination_reg;
   logic              decode_valid;
   logic [31:0]       execute_instr;
   logic [31:0]       execute_pc;
   logic [31:0]       execute_operand_a;
   logic [31:0]       execute_operand_b;
   logic [4:0]        execute_destination_reg;
   logic              execute_valid;
   logic              protocol_error;
   logic [31:0]       stall_count;

   int compared;
   int mismatched;

   // Model state: what each pipeline slot should contain after the most recent edge
   logic [31:0] mDecInstr;
   logic [31:0] mDecPc;
   logic        mDecValid;
   logic [31:0] mExInstr;
   logic [31:0] mExPc;
   logic [31:0] mExA;
   logic [31:0] mExB;
   logic [4:0]  mExDst;
   logic        mExValid;
   logic        mErr;
   logic [31:0] mStalls;

   localparam logic [31:0] NOP = 32'h00000013;

   decode_forward_stage dut (
      .clk                     (clock),
      .rst                     (rst),
      .fetch_instr             (fetch_instr),
      .fetch_pc                (fetch_pc),
      .fetch_valid             (fetch_valid),
      .flush                   (flush),
      .f_to_d_enable_ff        (f_to_d_enable_ff),
      .d_to_e_enable_ff        (d_to_e_enable_ff),
      .pipeline_forward_sel    (pipeline_forward_sel),
      .rf_data1                (rf_data1),
      .rf_data2                (rf_data2),
      .ex_alu_data             (ex_alu_data),
      .ma_alu_data             (ma_alu_data),
      .ma_dm_data              (ma_dm_data),
      .decode_source_reg1      (decode_source_reg1),
      .decode_source_reg2      (decode_source_reg2),
      .decode_destination_reg  (decode_destination_reg),
      .decode_valid            (decode_valid),
      .execute_instr           (execute_instr),
      .execute_pc              (execute_pc),
      .execute_operand_a       (execute_operand_a),
      .execute_operand_b       (execute_operand_b),
      .execute_destination_reg (execute_destination_reg),
      .execute_valid           (execute_valid),
      .protocol_error          (protocol_error),
      .stall_count             (stall_count)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Operand value an instruction should carry into execute, given its source field and the select
   function automatic logic [31:0] operandFor(input logic [4:0] src, input logic [1:0] sel,
                                               input logic [31:0] rfValue);
      if (src == 5'd0) return 32'd0;
      case (sel)
         2'd0:    return rfValue;
         2'd1:    return ma_dm_data;
         2'd2:    return ex_alu_data;
         default: return ma_alu_data;
      endcase
   endfunction

   // One comparison: count it, and report any difference with a FAIL line
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Clock one edge with the currently driven inputs, advancing the model by the same edge
   task automatic applyStimulus();
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        bubble;
      @(posedge clock);
      rs1 = mDecInstr[19:15];
      rs2 = mDecInstr[24:20];
      rd  = mDecInstr[11:7];
      if (!rst) begin
         mDecInstr = NOP; mDecPc = 0; mDecValid = 0;
         mExInstr = NOP; mExPc = 0; mExA = 0; mExB = 0; mExDst = 0; mExValid = 0;
         mErr = 0; mStalls = 0;
      end else begin
         bubble = flush || !d_to_e_enable_ff;
         if (!flush && !f_to_d_enable_ff && d_to_e_enable_ff) mErr = 1;
         if (bubble && !flush && mStalls != 32'hFFFFFFFF) mStalls = mStalls + 1;
         if (bubble) begin
            mExInstr = NOP; mExPc = 0; mExA = 0; mExB = 0; mExDst = 0; mExValid = 0;
         end else begin
            mExInstr = mDecInstr;
            mExPc    = mDecPc;
            mExA     = operandFor(rs1, pipeline_forward_sel[0], rf_data1);
            mExB     = operandFor(rs2, pipeline_forward_sel[1], rf_data2);
            mExDst   = mDecValid ? rd : 5'd0;
            mExValid = mDecValid;
         end
         if (flush) begin
            mDecInstr = NOP; mDecValid = 0;
         end else if (f_to_d_enable_ff) begin
            mDecInstr = fetch_instr; mDecPc = fetch_pc; mDecValid = fetch_valid;
         end
      end
      #1;
   endtask

   // Compare every observable output against the model
   task automatic checkAll(input string step);
      logic [31:0] expStalls;
`ifdef HAZARD_STALL_COUNT_EN
      expStalls = mStalls;
`else
      expStalls = 32'd0;
`endif
      checkOutput({step, ".rs1"},     32'(decode_source_reg1),      32'(mDecInstr[19:15]));
      checkOutput({step, ".rs2"},     32'(decode_source_reg2),      32'(mDecInstr[24:20]));
      checkOutput({step, ".rd"},      32'(decode_destination_reg),  32'(mDecInstr[11:7]));
      checkOutput({step, ".dvalid"},  32'(decode_valid),            32'(mDecValid));
      checkOutput({step, ".einstr"},  execute_instr,                mExInstr);
      checkOutput({step, ".epc"},     execute_pc,                   mExPc);
      checkOutput({step, ".opa"},     execute_operand_a,            mExA);
      checkOutput({step, ".opb"},     execute_operand_b,            mExB);
      checkOutput({step, ".edst"},    32'(execute_destination_reg), 32'(mExDst));
      checkOutput({step, ".evalid"},  32'(execute_valid),           32'(mExValid));
      checkOutput({step, ".perr"},    32'(protocol_error),          32'(mErr));
      checkOutput({step, ".stalls"},  stall_count,                  expStalls);
   endtask

   task automatic randomData();
      fetch_instr = $urandom;
      fetch_pc    = $urandom;
      rf_data1    = $urandom;
      rf_data2    = $urandom;
      ex_alu_data = $urandom;
      ma_alu_data = $urandom;
      ma_dm_data  = $urandom;
      pipeline_forward_sel[0] = 2'($urandom_range(0, 3));
      pipeline_forward_sel[1] = 2'($urandom_range(0, 3));
   endtask

   task automatic normalControls();
      rst = 1; flush = 0; f_to_d_enable_ff = 1; d_to_e_enable_ff = 1; fetch_valid = 1;
   endtask

   // Directed test-plan steps, then a randomized run, all in one sequence
   initial begin
      logic [31:0] expOne;
      compared   = 0;
      mismatched = 0;
      mDecInstr = 'x; mDecPc = 'x; mDecValid = 'x;
      mExInstr = 'x; mExPc = 'x; mExA = 'x; mExB = 'x; mExDst = 'x; mExValid = 'x;
      mErr = 'x; mStalls = 'x;
`ifdef HAZARD_STALL_COUNT_EN
      expOne = 32'd1;
`else
      expOne = 32'd0;
`endif

      rst = 0; flush = $urandom_range(0, 1); fetch_valid = 1;
      f_to_d_enable_ff = 1; d_to_e_enable_ff = 1;
      randomData();
      #2;

      for (int i = 0; i < 2; i++) begin
         randomData();
         flush = $urandom_range(0, 1);
         f_to_d_enable_ff = $urandom_range(0, 1);
         d_to_e_enable_ff = $urandom_range(0, 1);
         applyStimulus();
      end
      checkAll("reset");
      checkOutput("reset.einstr_const", execute_instr, 32'h00000013);

      $display("[TB] execute-stage forward on operand A");
      normalControls();
      randomData();
      fetch_instr = 32'h00208133;
      fetch_pc    = 32'h00000100;
      applyStimulus();
      checkAll("addA.fetch");
      fetch_instr = NOP;
      pipeline_forward_sel[0] = 2'd2;
      pipeline_forward_sel[1] = 2'd0;
      ex_alu_data = 32'h00001234;
      rf_data2    = 32'h00000005;
      applyStimulus();
      checkAll("addA.exec");
      checkOutput("addA.opa_const", execute_operand_a, 32'h00001234);
      checkOutput("addA.opb_const", execute_operand_b, 32'h00000005);
      checkOutput("addA.dst_const", 32'(execute_destination_reg), 32'd2);

      $display("[TB] load-use stall then DM forward");
      randomData();
      fetch_instr = 32'h00308233;
      fetch_pc    = 32'h00000104;
      applyStimulus();
      checkAll("lu.fetch");
      randomData();
      f_to_d_enable_ff = 0; d_to_e_enable_ff = 0;
      applyStimulus();
      checkAll("lu.stall");
      checkOutput("lu.stall_evalid", 32'(execute_valid), 32'd0);
      checkOutput("lu.stall_rs2held", 32'(decode_source_reg2), 32'd3);
      normalControls();
      randomData();
      pipeline_forward_sel[1] = 2'd1;
      ma_dm_data = 32'hDEADBEEF;
      applyStimulus();
      checkAll("lu.issue");
      checkOutput("lu.opb_const", execute_operand_b, 32'hDEADBEEF);
      checkOutput("lu.stalls_const", stall_count, expOne);

      $display("[TB] flush during stall");
      randomData();
      fetch_instr = 32'h002081B3;
      applyStimulus();
      checkAll("fl.fetch");
      randomData();
      flush = 1; f_to_d_enable_ff = 0; d_to_e_enable_ff = 0;
      applyStimulus();
      checkAll("fl.flush");
      checkOutput("fl.dvalid_const", 32'(decode_valid), 32'd0);
      checkOutput("fl.evalid_const", 32'(execute_valid), 32'd0);
      checkOutput("fl.rd_const", 32'(decode_destination_reg), 32'd0);
      checkOutput("fl.stalls_const", stall_count, expOne);

      $display("[TB] x0 source");
      normalControls();
      randomData();
      fetch_instr = 32'h00500093;
      applyStimulus();
      checkAll("x0.fetch");
      randomData();
      pipeline_forward_sel[0] = 2'd3;
      ma_alu_data = 32'hFFFFFFFF;
      applyStimulus();
      checkAll("x0.exec");
      checkOutput("x0.opa_const", execute_operand_a, 32'd0);

      $display("[TB] protocol error");
      randomData();
      f_to_d_enable_ff = 0; d_to_e_enable_ff = 1;
      applyStimulus();
      checkAll("pe.illegal");
      checkOutput("pe.set_const", 32'(protocol_error), 32'd1);
      normalControls();
      for (int i = 0; i < 5; i++) begin
         randomData();
         applyStimulus();
         checkAll("pe.sticky");
         checkOutput("pe.sticky_const", 32'(protocol_error), 32'd1);
      end
      rst = 0;
      applyStimulus();
      checkAll("pe.reset");
      checkOutput("pe.cleared_const", 32'(protocol_error), 32'd0);

      $display("[TB] randomized run");
      for (int i = 0; i < 300; i++) begin
         randomData();
         rst              = ($urandom_range(0, 49) != 0);
         flush            = ($urandom_range(0, 9) == 0);
         f_to_d_enable_ff = ($urandom_range(0, 5) != 0);
         d_to_e_enable_ff = ($urandom_range(0, 4) != 0);
         fetch_valid      = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) fetch_instr[19:15] = 5'd0;
         if ($urandom_range(0, 3) == 0) fetch_instr[24:20] = 5'd0;
         applyStimulus();
         checkAll("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
